dibit_packer: RTL and testbench

//  Downstream stage of the 2-bit shift register: consumes its MSB-first 2-bit symbol stream.

---
 rtl/dibit_packer.sv | 108 ++++++++++
 tb/tb_dibit_packer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dibit_packer.sv
// +----------------------------------------------------------------------------+
// | dibit_packer: packs an MSB-first 2-bit symbol stream into WORD_W-bit words |
// | queued in a DEPTH-entry valid/ready output FIFO.  Revision: 1.0            |
// +----------------------------------------------------------------------------+
`default_nettype none

module dibit_packer #(
   parameter int WORD_W = 8,
   parameter int DEPTH  = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           sym_valid,
   input  logic [1:0]                     sym_data,
   input  logic                           sym_last,
   output logic                           sym_ready,
   output logic                           word_valid,
   output logic [WORD_W-1:0]              word_data,
   output logic [$clog2(WORD_W/2+1)-1:0]  word_nsym,
   output logic                           word_last,
   input  logic                           word_ready,
   output logic [$clog2(DEPTH+1)-1:0]     level
);

   localparam int N   = WORD_W / 2;
   localparam int CW  = (N > 1) ? $clog2(N) : 1;
   localparam int NSW = $clog2(N + 1);
   localparam int LW  = $clog2(DEPTH + 1);
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0]     cnt;
   logic [WORD_W-1:0] acc;
   logic [WORD_W-1:0] acc_next;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              accept;
   logic              complete;
   logic              push;
   logic              pop;

   logic [WORD_W-1:0] mem_data [DEPTH];
   logic [NSW-1:0]    mem_nsym [DEPTH];
   logic              mem_last [DEPTH];

   assign sym_ready  = (level < LW'(DEPTH));
   assign word_valid = (level != '0);
   assign accept     = sym_valid & sym_ready;
   assign complete   = accept & (sym_last | (cnt == CW'(N - 1)));
   assign push       = complete;
   assign pop        = word_valid & word_ready;

   // Symbol k lands at the k-th dibit from the top; unfilled low bits stay zero.
   always_comb begin
      acc_next = acc;
      for (int k = 0; k < N; k++) begin
         if (cnt == CW'(k)) begin
            acc_next[WORD_W-1-2*k -: 2] = sym_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         acc    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (accept) begin
            if (complete) begin
               cnt <= '0;
               acc <= '0;
            end else begin
               cnt <= cnt + CW'(1);
               acc <= acc_next;
            end
         end
         if (push) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset: entries are only observed while counted in level.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= acc_next;
         mem_nsym[wr_ptr] <= NSW'(cnt) + NSW'(1);
         mem_last[wr_ptr] <= sym_last;
      end
   end

   assign word_data = word_valid ? mem_data[rd_ptr] : '0;
   assign word_nsym = word_valid ? mem_nsym[rd_ptr] : '0;
   assign word_last = word_valid ? mem_last[rd_ptr] : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_dibit_packer.sv
// +----------------------------------------------------------------------------+
// | tb_dibit_packer: directed vector table plus multi-cycle sequences.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dibit_packer;

   logic       clk;
   logic       rst_n;
   logic       sym_valid;
   logic [1:0] sym_data;
   logic       sym_last;
   logic       sym_ready;
   logic       word_valid;
   logic [7:0] word_data;
   logic [2:0] word_nsym;
   logic       word_last;
   logic       word_ready;
   logic [1:0] level;

   int total;
   int bad;

   dibit_packer #(.WORD_W(8), .DEPTH(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sym_valid  (sym_valid),
      .sym_data   (sym_data),
      .sym_last   (sym_last),
      .sym_ready  (sym_ready),
      .word_valid (word_valid),
      .word_data  (word_data),
      .word_nsym  (word_nsym),
      .word_last  (word_last),
      .word_ready (word_ready),
      .level      (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       v;
      logic [1:0] d;
      logic       l;
      logic       r;
      logic       e_wv;
      logic [7:0] e_data;
      logic [2:0] e_nsym;
      logic       e_last;
      logic [1:0] e_level;
      logic       e_rdy;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic wv, input logic [7:0] d,
                          input logic [2:0] ns, input logic ls, input logic [1:0] lv,
                          input logic rd);
      chk({tag, ".word_valid"}, 32'(word_valid), 32'(wv));
      chk({tag, ".word_data"},  32'(word_data),  32'(d));
      chk({tag, ".word_nsym"},  32'(word_nsym),  32'(ns));
      chk({tag, ".word_last"},  32'(word_last),  32'(ls));
      chk({tag, ".level"},      32'(level),      32'(lv));
      chk({tag, ".sym_ready"},  32'(sym_ready),  32'(rd));
   endtask

   // Offers one symbol until accepted; called and returns at posedge+1.
   task automatic send_sym(input logic [1:0] d, input logic l);
      int   waited;
      logic took;
      waited    = 0;
      took      = 1'b0;
      sym_valid = 1'b1;
      sym_data  = d;
      sym_last  = l;
      while (!took && waited < 50) begin
         took = sym_ready;
         @(posedge clk);
         #1;
         waited++;
      end
      if (!took) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got ready=0 expected ready=1 within 50 cycles");
      end
      sym_valid = 1'b0;
      sym_last  = 1'b0;
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst_n      = 1'b0;
      sym_valid  = 1'b0;
      sym_data   = 2'b00;
      sym_last   = 1'b0;
      word_ready = 1'b0;

      //           v     d      l     r     wv    data   nsym  last  lvl   rdy
      vecs[0] = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 2'd0, 1'b1};
      vecs[1] = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 2'd0, 1'b1};
      vecs[2] = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 2'd0, 1'b1};
      vecs[3] = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 8'hC9, 3'd4, 1'b0, 2'd1, 1'b1};
      vecs[4] = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 2'd0, 1'b1};
      vecs[5] = '{1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'h60, 3'd2, 1'b1, 2'd1, 1'b1};
      vecs[6] = '{1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'h80, 3'd1, 1'b1, 2'd1, 1'b1};
      vecs[7] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 2'd0, 1'b1};
      vecs[8] = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 2'd0, 1'b1};

      #3;
      chk_out("reset", 1'b0, 8'h00, 3'd0, 1'b0, 2'd0, 1'b1);
      #19 rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) begin
         sym_valid  = vecs[i].v;
         sym_data   = vecs[i].d;
         sym_last   = vecs[i].l;
         word_ready = vecs[i].r;
         @(posedge clk);
         #1;
         chk_out($sformatf("vec%0d", i), vecs[i].e_wv, vecs[i].e_data, vecs[i].e_nsym,
                 vecs[i].e_last, vecs[i].e_level, vecs[i].e_rdy);
      end
      sym_valid = 1'b0;
      sym_last  = 1'b0;

      // Backpressure: two words fill the FIFO, the third stalls.
      word_ready = 1'b0;
      send_sym(2'b00, 1'b0); send_sym(2'b01, 1'b0); send_sym(2'b10, 1'b0); send_sym(2'b11, 1'b0);
      send_sym(2'b11, 1'b0); send_sym(2'b10, 1'b0); send_sym(2'b01, 1'b0); send_sym(2'b00, 1'b0);
      chk_out("full", 1'b1, 8'h1B, 3'd4, 1'b0, 2'd2, 1'b0);
      sym_valid = 1'b1;
      sym_data  = 2'b10;
      repeat (3) @(posedge clk);
      #1;
      chk_out("stall", 1'b1, 8'h1B, 3'd4, 1'b0, 2'd2, 1'b0);
      sym_valid  = 1'b0;
      word_ready = 1'b1;
      @(posedge clk);
      #1;
      word_ready = 1'b0;
      chk_out("pop1", 1'b1, 8'hE4, 3'd4, 1'b0, 2'd1, 1'b1);
      send_sym(2'b10, 1'b0); send_sym(2'b10, 1'b0); send_sym(2'b10, 1'b0); send_sym(2'b10, 1'b0);
      chk_out("refill", 1'b1, 8'hE4, 3'd4, 1'b0, 2'd2, 1'b0);
      word_ready = 1'b1;
      @(posedge clk);
      #1;
      chk_out("drain1", 1'b1, 8'hAA, 3'd4, 1'b0, 2'd1, 1'b1);
      @(posedge clk);
      #1;
      chk_out("drain2", 1'b0, 8'h00, 3'd0, 1'b0, 2'd0, 1'b1);

      // Mid-word asynchronous reset discards FIFO contents and partial word.
      word_ready = 1'b0;
      send_sym(2'b11, 1'b0); send_sym(2'b00, 1'b0); send_sym(2'b11, 1'b0); send_sym(2'b00, 1'b0);
      send_sym(2'b11, 1'b0); send_sym(2'b11, 1'b0);
      chk_out("prereset", 1'b1, 8'hCC, 3'd4, 1'b0, 2'd1, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      chk_out("async_rst", 1'b0, 8'h00, 3'd0, 1'b0, 2'd0, 1'b1);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      word_ready = 1'b1;
      send_sym(2'b01, 1'b0); send_sym(2'b01, 1'b0); send_sym(2'b01, 1'b0); send_sym(2'b01, 1'b0);
      chk_out("post_rst", 1'b1, 8'h55, 3'd4, 1'b0, 2'd1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
